// File: rtl/arb_mux_n_pkg.sv
// Shared definitions for the arb_mux_n stream multiplexer: mode encodings,
// lock FSM state type and the selector-width helper.
package arb_mux_n_pkg;

    localparam logic ARB_MODE_FIXED = 1'b0;
    localparam logic ARB_MODE_RR    = 1'b1;

    typedef enum logic {
        ARB_ST_IDLE   = 1'b0,
        ARB_ST_LOCKED = 1'b1
    } arb_state_e;

    // A two-input mux still needs one selector bit, so the width never drops to zero.
    function automatic int arbSelWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_n_rr_grant.sv
// Rotating-priority encoder: picks the first requesting channel at or above
// the pointer, wrapping from the top channel back to channel 0.
module rr_grant #(
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_IN-1:0]  i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_gnt,
    output logic             o_gntVld
);

    // Scan offsets from the farthest to the nearest so that the request closest
    // to the pointer is the last one written and therefore wins.
    always_comb begin
        int idx;
        idx      = 0;
        o_gnt    = '0;
        o_gntVld = 1'b0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = int'(i_ptr) + k;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            if (i_req[idx]) begin
                o_gnt    = SEL_W'(idx);
                o_gntVld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-input stream multiplexer with valid/ready handshake and one registered
// output stage. The source is chosen by an explicit selector or by round-robin.
// Optional packet locking is enabled by defining ARB_LOCK_EN, which adds the
// in_last port and keeps a granted channel until its last beat.
module arb_mux_n
    import arb_mux_n_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SEL_W = arbSelWidth(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
`ifdef ARB_LOCK_EN
    input  logic [N_IN-1:0]       in_last,
`endif
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_src,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [SEL_W-1:0]  r_src;
    logic [SEL_W-1:0]  r_rrPtr;

    logic              w_load;
    logic              w_xfer;
    logic              w_gntVld;
    logic              w_rrVld;
    logic              w_fixVld;
    logic              w_ptrUpd;
    logic [SEL_W-1:0]  w_gnt;
    logic [SEL_W-1:0]  w_rrGnt;
    logic [SEL_W-1:0]  w_nextPtr;
    logic [WIDTH-1:0]  w_gntData;

    assign w_load    = !r_valid || out_ready;
    assign w_xfer    = w_load && w_gntVld;
    assign w_nextPtr = (w_gnt == SEL_W'(N_IN - 1)) ? '0 : w_gnt + SEL_W'(1);

    rr_grant #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_rrGrant (
        .i_req    (in_valid),
        .i_ptr    (r_rrPtr),
        .o_gnt    (w_rrGnt),
        .o_gntVld (w_rrVld)
    );

    // In fixed mode only a selector that names an existing channel can win;
    // an out-of-range selector matches nothing and so never grants.
    always_comb begin
        w_fixVld = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                w_fixVld = in_valid[i];
            end
        end
    end

`ifdef ARB_LOCK_EN
    arb_state_e        r_state;
    arb_state_e        w_stateNext;
    logic [SEL_W-1:0]  r_lockCh;
    logic [SEL_W-1:0]  w_lockChNext;
    logic              w_lockVld;
    logic              w_gntLast;

    // While locked, the only request that matters is the locked channel's valid.
    always_comb begin
        w_lockVld = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (r_lockCh == SEL_W'(i)) begin
                w_lockVld = in_valid[i];
            end
        end
    end

    // End-of-packet flag of whichever channel currently holds the grant.
    always_comb begin
        w_gntLast = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_gntLast = in_last[i];
            end
        end
    end

    // A non-final beat locks the grant onto its channel; the final beat releases it.
    always_comb begin
        w_stateNext  = r_state;
        w_lockChNext = r_lockCh;
        case (r_state)
            ARB_ST_IDLE: begin
                if (w_xfer && !w_gntLast) begin
                    w_stateNext  = ARB_ST_LOCKED;
                    w_lockChNext = w_gnt;
                end
            end
            ARB_ST_LOCKED: begin
                if (w_xfer && w_gntLast) begin
                    w_stateNext = ARB_ST_IDLE;
                end
            end
        endcase
    end

    // Lock state register; reset abandons any packet in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ARB_ST_IDLE;
            r_lockCh <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_lockCh <= w_lockChNext;
        end
    end

    assign w_ptrUpd = w_xfer && w_gntLast;
`else
    assign w_ptrUpd = w_xfer;
`endif

    // Final grant: the mode picks the source, and an active packet lock overrides both modes.
    always_comb begin
        w_gnt    = '0;
        w_gntVld = 1'b0;
        if (mode == ARB_MODE_RR) begin
            w_gnt    = w_rrGnt;
            w_gntVld = w_rrVld;
        end else if (mode == ARB_MODE_FIXED) begin
            w_gnt    = sel;
            w_gntVld = w_fixVld;
        end
`ifdef ARB_LOCK_EN
        if (r_state == ARB_ST_LOCKED) begin
            w_gnt    = r_lockCh;
            w_gntVld = w_lockVld;
        end
`endif
    end

    // Route the granted channel's data towards the output register.
    always_comb begin
        w_gntData = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_gntData = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Only the granted channel sees ready, and only when the output stage can take a beat.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_ready[i] = w_xfer && (w_gnt == SEL_W'(i));
        end
    end

    // Output stage: load a granted beat, drop valid when nothing is granted, hold under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (w_load) begin
            if (w_gntVld) begin
                r_valid <= 1'b1;
                r_data  <= w_gntData;
                r_src   <= w_gnt;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer advances past each granted source in every mode,
    // so switching into round-robin continues fairly from the last winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPtr <= '0;
        end else if (w_ptrUpd) begin
            r_rrPtr <= w_nextPtr;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed testbench for arb_mux_n: a 4-input instance for the main scenarios
// and a 3-input instance for out-of-range selection and pointer wrap.
// The packet-lock scenario is included when ARB_LOCK_EN is defined.
module tb_arb_mux_n;

    logic        clk;
    logic        reset;

    logic [31:0] inData;
    logic [3:0]  inValid;
    logic [3:0]  inReady;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  outData;
    logic [1:0]  outSrc;
    logic        outValid;
    logic        outReady;

    logic [23:0] inData3;
    logic [2:0]  inValid3;
    logic [2:0]  inReady3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  outData3;
    logic [1:0]  outSrc3;
    logic        outValid3;
    logic        outReady3;

`ifdef ARB_LOCK_EN
    logic [3:0]  inLast;
    logic [2:0]  inLast3;
`endif

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] chVal [4];

    arb_mux_n #(
        .WIDTH (8),
        .N_IN  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .mode      (mode),
        .sel       (sel),
`ifdef ARB_LOCK_EN
        .in_last   (inLast),
`endif
        .out_data  (outData),
        .out_src   (outSrc),
        .out_valid (outValid),
        .out_ready (outReady)
    );

    arb_mux_n #(
        .WIDTH (8),
        .N_IN  (3)
    ) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (inData3),
        .in_valid  (inValid3),
        .in_ready  (inReady3),
        .mode      (mode3),
        .sel       (sel3),
`ifdef ARB_LOCK_EN
        .in_last   (inLast3),
`endif
        .out_data  (outData3),
        .out_src   (outSrc3),
        .out_valid (outValid3),
        .out_ready (outReady3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison goes through here so the counts stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where registered outputs are stable.
    task automatic applyStimulus;
        @(posedge clk);
        #1;
    endtask

    // Directed sequence of scenarios, each with hand-computed expectations.
    initial begin
        chVal[0] = 8'h10;
        chVal[1] = 8'h21;
        chVal[2] = 8'h33;
        chVal[3] = 8'h44;

        reset     = 1'b1;
        inData    = '0;
        inValid   = '0;
        mode      = 1'b0;
        sel       = '0;
        outReady  = 1'b1;
        inData3   = '0;
        inValid3  = '0;
        mode3     = 1'b0;
        sel3      = '0;
        outReady3 = 1'b1;
`ifdef ARB_LOCK_EN
        inLast    = 4'b1111;
        inLast3   = 3'b111;
`endif

        applyStimulus();
        applyStimulus();
        checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("rst_out_data", {24'd0, outData}, 32'd0);
        checkOutput("rst_out_src", {30'd0, outSrc}, 32'd0);
        checkOutput("rst_in_ready", {28'd0, inReady}, 32'd0);
        reset = 1'b0;

        // Load a beat, then reset between edges while it is held.
        sel     = 2'd1;
        inValid = 4'b0010;
        inData  = {8'h00, 8'h00, 8'h5A, 8'h00};
        applyStimulus();
        checkOutput("pre_rst_valid", {31'd0, outValid}, 32'd1);
        checkOutput("pre_rst_data", {24'd0, outData}, 32'h5A);
        inValid  = 4'b0000;
        outReady = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'd0, outValid}, 32'd0);
        checkOutput("mid_rst_data", {24'd0, outData}, 32'd0);
        checkOutput("mid_rst_src", {30'd0, outSrc}, 32'd0);
        applyStimulus();
        reset    = 1'b0;
        outReady = 1'b1;

        // Fixed mode, sel=2, every channel valid.
        inData  = {chVal[3], chVal[2], chVal[1], chVal[0]};
        mode    = 1'b0;
        sel     = 2'd2;
        inValid = 4'b1111;
        #1;
        checkOutput("fix_in_ready", {28'd0, inReady}, 32'b0100);
        applyStimulus();
        checkOutput("fix_out_valid", {31'd0, outValid}, 32'd1);
        checkOutput("fix_out_data", {24'd0, outData}, 32'h33);
        checkOutput("fix_out_src", {30'd0, outSrc}, 32'd2);

        // Selected channel idle: no ready, output empties, data holds.
        inValid = 4'b1011;
        #1;
        checkOutput("fix_idle_ready", {28'd0, inReady}, 32'd0);
        applyStimulus();
        checkOutput("fix_idle_valid", {31'd0, outValid}, 32'd0);
        checkOutput("fix_idle_data", {24'd0, outData}, 32'h33);
        checkOutput("fix_idle_src", {30'd0, outSrc}, 32'd2);

        // Ready of the selected channel does not depend on the others' valid.
        inValid = 4'b0100;
        #1;
        checkOutput("fix_alone_ready", {28'd0, inReady}, 32'b0100);
        applyStimulus();

        // Fixed transfer from channel 3 leaves the round-robin pointer at 0.
        sel     = 2'd3;
        inValid = 4'b1000;
        applyStimulus();
        checkOutput("fix3_src", {30'd0, outSrc}, 32'd3);
        checkOutput("fix3_data", {24'd0, outData}, 32'h44);

        // Round-robin with all channels valid: 0,1,2,3,0,1,2,3.
        mode    = 1'b1;
        inValid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            checkOutput($sformatf("rr_all_src%0d", k), {30'd0, outSrc}, 32'(k % 4));
            checkOutput($sformatf("rr_all_data%0d", k), {24'd0, outData}, {24'd0, chVal[k % 4]});
        end

        // Channels 1 and 3 only, pointer back at 0: 1,3,1,3.
        inValid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput($sformatf("rr_1010_src%0d", k), {30'd0, outSrc}, (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Backpressure: a 0x11 beat from channel 0 is held for three stalled cycles.
        inValid = 4'b0001;
        inData  = {chVal[3], chVal[2], chVal[1], 8'h11};
        applyStimulus();
        checkOutput("bp_load_data", {24'd0, outData}, 32'h11);
        outReady = 1'b0;
        inValid  = 4'b1111;
        inData   = {chVal[3], chVal[2], chVal[1], 8'h99};
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("bp_ready%0d", k), {28'd0, inReady}, 32'd0);
            applyStimulus();
            checkOutput($sformatf("bp_data%0d", k), {24'd0, outData}, 32'h11);
            checkOutput($sformatf("bp_valid%0d", k), {31'd0, outValid}, 32'd1);
        end
        outReady = 1'b1;
        #1;
        checkOutput("bp_release_ready", {28'd0, inReady}, 32'b0010);
        applyStimulus();
        checkOutput("bp_release_src", {30'd0, outSrc}, 32'd1);
        checkOutput("bp_release_data", {24'd0, outData}, 32'h21);
        inValid = 4'b0000;
        applyStimulus();
        checkOutput("drain_valid", {31'd0, outValid}, 32'd0);

        // Three-input instance: selector 3 names no channel.
        inData3  = {8'hC2, 8'hB1, 8'hA0};
        mode3    = 1'b0;
        sel3     = 2'd3;
        inValid3 = 3'b111;
        #1;
        checkOutput("n3_sel3_ready", {29'd0, inReady3}, 32'd0);
        applyStimulus();
        checkOutput("n3_sel3_valid", {31'd0, outValid3}, 32'd0);
        sel3 = 2'd2;
        applyStimulus();
        checkOutput("n3_sel2_src", {30'd0, outSrc3}, 32'd2);
        checkOutput("n3_sel2_data", {24'd0, outData3}, 32'hC2);
        mode3 = 1'b1;
        applyStimulus();
        checkOutput("n3_wrap_src", {30'd0, outSrc3}, 32'd0);
        applyStimulus();
        checkOutput("n3_next_src", {30'd0, outSrc3}, 32'd1);
        inValid3 = 3'b000;

`ifdef ARB_LOCK_EN
        // Packet lock: start with the pointer at 1 via a single-beat fixed transfer from channel 0.
        reset = 1'b1;
        applyStimulus();
        reset   = 1'b0;
        inData  = {chVal[3], chVal[2], chVal[1], chVal[0]};
        mode    = 1'b0;
        sel     = 2'd0;
        inValid = 4'b0001;
        inLast  = 4'b1111;
        applyStimulus();
        checkOutput("lk_pre_src", {30'd0, outSrc}, 32'd0);

        mode    = 1'b1;
        inValid = 4'b0111;
        inLast  = 4'b1101;
        applyStimulus();
        checkOutput("lk_beat1_src", {30'd0, outSrc}, 32'd1);
        mode = 1'b0;
        sel  = 2'd0;
        applyStimulus();
        checkOutput("lk_beat2_src", {30'd0, outSrc}, 32'd1);
        mode   = 1'b1;
        inLast = 4'b1111;
        applyStimulus();
        checkOutput("lk_beat3_src", {30'd0, outSrc}, 32'd1);
        applyStimulus();
        checkOutput("lk_after_src", {30'd0, outSrc}, 32'd2);

        // Lock onto channel 0, then reset while locked.
        inLast = 4'b0000;
        applyStimulus();
        checkOutput("lk_ch0_src", {30'd0, outSrc}, 32'd0);
        inValid = 4'b0110;
        inLast  = 4'b1111;
        #2;
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        #1;
        checkOutput("lk_rst_ready", {28'd0, inReady}, 32'b0010);
        applyStimulus();
        checkOutput("lk_rst_src", {30'd0, outSrc}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
